// File: rtl/instrumented_adder_ripple_wrapper.sv
// -----------------------------------------------------------------------------
// instrumented_adder_ripple_wrapper
//
// Caravel-style user-project wrapper around a 32-bit ripple-carry adder that is
// closed into a feedback loop. Some operand-A bits come from a feedback bit
// (chain_out), and chain_out is rebuilt each cycle from selected sum bits.
// When the loop oscillates, an event counter records rising edges of chain_out.
// Software configures and observes the block over the logic-analyzer buses.
//
// Ports:
//   wb_clk_i      single clock, all state changes on its rising edge
//   wb_rst_i      synchronous active-high reset
//   active        project select; 0 forces every output to its inactive value
//   la1_data_in   register write data
//   la2_data_in   unused
//   la3_data_in   [2:0] register address, [3] write enable, rest unused
//   la1_oenb, la2_oenb, la3_oenb, io_in   unused
//   la1_data_out  event counter
//   la2_data_out  registered adder sum
//   la3_data_out  {28'b0, carry_out, chain_out, 1'b0, run}
//   io_out        bit 8 carries chain_out, all other bits 0
//   io_oeb        all 0 while active, all 1 while inactive
//
// Register map (written when la3_data_in[3] = 1):
//   0 a_input, 1 b_input, 2 a_ext_mask, 3 ring_mask, 4 s_sel_mask,
//   5 control (bit0 = run, bit1 = one-shot counter clear), 6-7 ignored
// -----------------------------------------------------------------------------
module instrumented_adder_ripple_wrapper #(
  parameter int WIDTH = 32
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        active,
  input  logic [31:0] la1_data_in,
  input  logic [31:0] la2_data_in,
  input  logic [31:0] la3_data_in,
  input  logic [31:0] la1_oenb,
  input  logic [31:0] la2_oenb,
  input  logic [31:0] la3_oenb,
  input  logic [37:0] io_in,
  output logic [31:0] la1_data_out,
  output logic [31:0] la2_data_out,
  output logic [31:0] la3_data_out,
  output logic [37:0] io_out,
  output logic [37:0] io_oeb
);

  // Configuration registers
  logic [WIDTH-1:0] a_input;
  logic [WIDTH-1:0] b_input;
  logic [WIDTH-1:0] a_ext_mask;
  logic [WIDTH-1:0] ring_mask;
  logic [WIDTH-1:0] s_sel_mask;
  logic             run;

  // Loop and measurement state
  logic             chain_out;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] sum_reg;
  logic             carry_reg;

  // Datapath
  logic [WIDTH-1:0] a_eff;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             ripple_c;
  logic             fb;
  logic             chain_next;
  logic             count_inc;

  // Write decode
  logic       wr_en;
  logic [2:0] wr_addr;
  logic       clear_pulse;

  // Inputs that the wrapper deliberately does not use, folded together so the
  // intent is explicit.
  logic unused_inputs;
  assign unused_inputs = ^{la2_data_in, la3_data_in[31:4], la1_oenb, la2_oenb,
                           la3_oenb, io_in};

  assign wr_en       = la3_data_in[3];
  assign wr_addr     = la3_data_in[2:0];
  assign clear_pulse = wr_en && (wr_addr == 3'd5) && la1_data_in[1];

  // Ring bits take the feedback value and override the external operand.
  assign a_eff = (ring_mask & {WIDTH{chain_out}})
               | (~ring_mask & a_ext_mask & a_input);

  // Ripple-carry adder: one full adder per bit, carry passed bit to bit. The
  // carry is a loop-local variable so the chain stays a true ripple structure.
  always_comb begin
    ripple_c = 1'b0;
    sum      = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]   = a_eff[i] ^ b_input[i] ^ ripple_c;
      ripple_c = (a_eff[i] & b_input[i]) | (ripple_c & (a_eff[i] ^ b_input[i]));
    end
    carry_out = ripple_c;
  end

  // The feedback uses the live sum so the loop closes through the adder in a
  // single cycle; inverting it makes a one-bit ring oscillate.
  assign fb         = |(sum & s_sel_mask);
  assign chain_next = run ? ~fb : 1'b0;
  assign count_inc  = run && !chain_out && chain_next;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      a_input    <= '0;
      b_input    <= '0;
      a_ext_mask <= '0;
      ring_mask  <= WIDTH'(32'h0000_0020);
      s_sel_mask <= WIDTH'(32'h0000_0020);
      run        <= 1'b0;
    end else if (wr_en) begin
      case (wr_addr)
        3'd0:    a_input    <= la1_data_in;
        3'd1:    b_input    <= la1_data_in;
        3'd2:    a_ext_mask <= la1_data_in;
        3'd3:    ring_mask  <= la1_data_in;
        3'd4:    s_sel_mask <= la1_data_in;
        3'd5:    run        <= la1_data_in[0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      chain_out <= 1'b0;
      count     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
    end else begin
      chain_out <= chain_next;
      sum_reg   <= sum;
      carry_reg <= carry_out;
      // Clear takes precedence over a coincident rising edge.
      if (clear_pulse) begin
        count <= '0;
      end else if (count_inc) begin
        count <= count + 1'b1;
      end
    end
  end

  // Output gating: state keeps running regardless of active.
  always_comb begin
    la1_data_out = '0;
    la2_data_out = '0;
    la3_data_out = '0;
    io_out       = '0;
    io_oeb       = '1;
    if (active) begin
      la1_data_out = count;
      la2_data_out = sum_reg;
      la3_data_out = {28'b0, carry_reg, chain_out, 1'b0, run};
      io_out[8]    = chain_out;
      io_oeb       = '0;
    end
  end

endmodule

// File: tb/tb_instrumented_adder_ripple_wrapper.sv
// -----------------------------------------------------------------------------
// Directed bench for instrumented_adder_ripple_wrapper. A table of static-add
// vectors is applied in a loop; the oscillation, carry-loop, clear, wrap and
// gating corner cases are hand-written sequences with hand-derived values.
// -----------------------------------------------------------------------------
module tb_instrumented_adder_ripple_wrapper;

  // Clock / reset
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        active = 1'b1;
  logic [31:0] la1_in = '0;
  logic [31:0] la2_in = '0;
  logic [31:0] la3_in = '0;
  logic [31:0] oenb = '0;
  logic [37:0] io_in = '0;
  logic [31:0] la1_out;
  logic [31:0] la2_out;
  logic [31:0] la3_out;
  logic [37:0] io_out;
  logic [37:0] io_oeb;

  always #5 clk = ~clk;

  instrumented_adder_ripple_wrapper dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .active       (active),
    .la1_data_in  (la1_in),
    .la2_data_in  (la2_in),
    .la3_data_in  (la3_in),
    .la1_oenb     (oenb),
    .la2_oenb     (oenb),
    .la3_oenb     (oenb),
    .io_in        (io_in),
    .la1_data_out (la1_out),
    .la2_data_out (la2_out),
    .la3_data_out (la3_out),
    .io_out       (io_out),
    .io_oeb       (io_oeb)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  // Static-add vectors: run=0, ring_mask=0
  typedef struct {
    logic [31:0] a_ext;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_sum;
    logic        exp_carry;
  } add_vec_t;

  add_vec_t vecs[7];

  // Driver tasks: step to 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [2:0] addr, input logic [31:0] data);
    la1_in = data;
    la3_in = {28'b0, 1'b1, addr};
    tick();
    la1_in = '0;
    la3_in = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
  endtask

  // Scoreboard check
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  initial begin
    vecs[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1};
    vecs[1] = '{32'hFFFF_FFFF, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0};
    vecs[2] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1};
    vecs[3] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1};
    vecs[5] = '{32'hFFFF_FFFF, 32'h0F0F_0F0F, 32'hF0F0_F0F1, 32'h0000_0000, 1'b1};
    vecs[6] = '{32'h0000_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0001_0000, 1'b0};

    // Reset defaults
    do_reset();
    check("rst_la1", 64'(la1_out), 64'h0);
    check("rst_la2", 64'(la2_out), 64'h0);
    check("rst_la3", 64'(la3_out), 64'h0);
    check("rst_io_out", 64'(io_out), 64'h0);
    check("rst_io_oeb", 64'(io_oeb), 64'h0);

    // Default oscillation: ring bit 5 inside s_sel bit 5, b=0.
    // After the run write chain_out is 0; k edges later chain = k%2,
    // count = ceil(k/2).
    wr(3'd5, 32'h1);
    check("osc_run", 64'(la3_out), 64'h1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("osc_chain", 64'(la3_out[2]), 64'(k % 2));
      check("osc_io8", 64'(io_out), 64'(k % 2) << 8);
    end
    ticks(16);
    check("osc_count20", 64'(la1_out), 64'd10);

    // Static adds, table driven
    do_reset();
    wr(3'd3, 32'h0);
    for (int v = 0; v < 7; v++) begin
      wr(3'd2, vecs[v].a_ext);
      wr(3'd0, vecs[v].a);
      wr(3'd1, vecs[v].b);
      tick();
      check("add_sum", 64'(la2_out), 64'(vecs[v].exp_sum));
      check("add_la3", 64'(la3_out), 64'({vecs[v].exp_carry, 3'b000}));
    end

    // Carry-path loop: a_eff = 0x7FFFFFFE | chain, b=1. chain=1 carries
    // through bits 0..30 into sum[31], so fb = chain and chain toggles.
    do_reset();
    wr(3'd3, 32'h0000_0001);
    wr(3'd4, 32'h8000_0000);
    wr(3'd2, 32'hFFFF_FFFE);
    wr(3'd0, 32'h7FFF_FFFE);
    wr(3'd1, 32'h0000_0001);
    wr(3'd5, 32'h1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("carry_chain", 64'(la3_out), 64'({1'b0, 1'(k % 2), 2'b01}));
      if (k % 2 == 1) check("carry_sum", 64'(la2_out), 64'h7FFF_FFFF);
      else            check("carry_sum", 64'(la2_out), 64'h8000_0000);
    end
    check("carry_count", 64'(la1_out), 64'd4);

    // a_input=0xFFFFFFFE, b=0: sum[31] is always 1, fb=1, chain settles at 0.
    wr(3'd0, 32'hFFFF_FFFE);
    wr(3'd1, 32'h0000_0000);
    ticks(3);
    check("settle0_chain", 64'(la3_out[2]), 64'd0);
    check("settle0_count", 64'(la1_out), 64'd5);

    // Empty s_sel: fb=0, chain rises once to 1 and stays there.
    wr(3'd4, 32'h0);
    ticks(4);
    check("settle1_chain", 64'(la3_out[2]), 64'd1);
    check("settle1_count", 64'(la1_out), 64'd6);
    ticks(3);
    check("settle1_hold", 64'(la1_out), 64'd6);

    // Clear while counting, then counting resumes
    do_reset();
    wr(3'd5, 32'h1);
    ticks(7);
    check("clr_pre", 64'(la1_out), 64'd4);
    wr(3'd5, 32'h3);
    check("clr_zero", 64'(la1_out), 64'd0);
    check("clr_run_kept", 64'(la3_out[0]), 64'd1);
    ticks(4);
    check("clr_resume", 64'(la1_out), 64'd2);

    // Wrap: stop, preload count to all ones, restart.
    wr(3'd5, 32'h0);
    tick();
    dut.count = 32'hFFFF_FFFF;
    #1;
    check("wrap_preload", 64'(la1_out), 64'hFFFF_FFFF);
    wr(3'd5, 32'h1);
    check("wrap_hold", 64'(la1_out), 64'hFFFF_FFFF);
    tick();
    check("wrap_zero", 64'(la1_out), 64'h0);
    check("wrap_chain", 64'(la3_out[2]), 64'd1);
    ticks(2);
    check("wrap_next", 64'(la1_out), 64'd1);

    // Gating mid-run: count is 1, chain currently 1
    active = 1'b0;
    #1;
    check("gate_la1", 64'(la1_out), 64'h0);
    check("gate_la2", 64'(la2_out), 64'h0);
    check("gate_la3", 64'(la3_out), 64'h0);
    check("gate_io_out", 64'(io_out), 64'h0);
    check("gate_io_oeb", 64'(io_oeb), 64'h3F_FFFF_FFFF);
    ticks(6);
    active = 1'b1;
    #1;
    check("gate_count", 64'(la1_out), 64'd4);
    check("gate_io_oeb_on", 64'(io_oeb), 64'h0);

    // Final report
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
